alu4_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 4-bit ALU (alu4, instantiated inside this block). Each requester presents operands and an opcode with a level request. The block grants one requester, latches its operands, and runs the ALU for one cycle. It returns a registered result with C/N/Z/V flags and a one-cycle done strobe. It sits between two client datapaths (e.g. two register-file ports) and the single ALU instance.

---
 rtl/alu4_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_alu4_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu4_arbiter.sv
// Two-requester round-robin front end for a shared 4-bit ALU.
// A transaction is IDLE -> EXEC -> DONE; the granted requester's operands are
// latched on entry to EXEC and the registered result/flags update on EXEC -> DONE.

// Combinational 4-bit ALU with C/N/Z/V flags.
// Opcodes: 000 NOT A, 001 NOT B, 010 AND, 011 OR, 100 XOR, 101 XNOR, 110 ADD, 111 SUB.
module alu4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic [3:0] y,
  output logic       c,
  output logic       n,
  output logic       z,
  output logic       v
);
  localparam int unsigned DW = 4;

  logic [DW:0] sum;

  // Operation select; logic ops leave carry and overflow clear.
  always_comb begin
    y   = '0;
    c   = 1'b0;
    v   = 1'b0;
    sum = '0;
    unique case (op)
      3'b000: y = ~a;
      3'b001: y = ~b;
      3'b010: y = a & b;
      3'b011: y = a | b;
      3'b100: y = a ^ b;
      3'b101: y = ~(a ^ b);
      3'b110: begin
        sum = {1'b0, a} + {1'b0, b};
        y   = sum[DW-1:0];
        c   = sum[DW];
        v   = (a[DW-1] == b[DW-1]) && (y[DW-1] != a[DW-1]);
      end
      default: begin
        // Subtract as a + ~b + 1, so carry means "no borrow".
        sum = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1);
        y   = sum[DW-1:0];
        c   = sum[DW];
        v   = (a[DW-1] != b[DW-1]) && (y[DW-1] != a[DW-1]);
      end
    endcase
    n = y[DW-1];
    z = (y == '0);
  end
endmodule

module alu4_arbiter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [2:0] op0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic [2:0] op1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] result,
  output logic       c,
  output logic       n,
  output logic       z,
  output logic       v
);
  localparam int unsigned DW = 4;
  localparam int unsigned OW = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    EXEC    = 2'b01,
    DONE    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t          state, state_d;
  logic            last, last_d;
  logic            sel, sel_d;
  logic [DW-1:0]   a_lat, a_d;
  logic [DW-1:0]   b_lat, b_d;
  logic [OW-1:0]   op_lat, op_d;
  logic            gnt0_d, gnt1_d, done0_d, done1_d;
  logic [DW-1:0]   result_d;
  logic            c_d, n_d, z_d, v_d;
  logic            win1_c;

  logic [DW-1:0]   alu_y;
  logic            alu_c, alu_n, alu_z, alu_v;

  alu4 u_alu (
    .a  (a_lat),
    .b  (b_lat),
    .op (op_lat),
    .y  (alu_y),
    .c  (alu_c),
    .n  (alu_n),
    .z  (alu_z),
    .v  (alu_v)
  );

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign win1_c = req1 & (~req0 | ~last);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = IDLE;
    unique case (state)
      IDLE:    state_d = (req0 | req1) ? EXEC : IDLE;
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the operand latches, pointer, strobes and result registers.
  always_comb begin
    last_d   = last;
    sel_d    = sel;
    a_d      = a_lat;
    b_d      = b_lat;
    op_d     = op_lat;
    gnt0_d   = gnt0;
    gnt1_d   = gnt1;
    done0_d  = done0;
    done1_d  = done1;
    result_d = result;
    c_d      = c;
    n_d      = n;
    z_d      = z;
    v_d      = v;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          sel_d  = win1_c;
          a_d    = win1_c ? a1  : a0;
          b_d    = win1_c ? b1  : b0;
          op_d   = win1_c ? op1 : op0;
          gnt0_d = ~win1_c;
          gnt1_d = win1_c;
        end
      end
      EXEC: begin
        result_d = alu_y;
        c_d      = alu_c;
        n_d      = alu_n;
        z_d      = alu_z;
        v_d      = alu_v;
        done0_d  = ~sel;
        done1_d  = sel;
      end
      DONE: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        last_d  = sel;
      end
      default: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last   <= 1'b1;
      sel    <= 1'b0;
      a_lat  <= '0;
      b_lat  <= '0;
      op_lat <= '0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      result <= '0;
      c      <= 1'b0;
      n      <= 1'b0;
      z      <= 1'b0;
      v      <= 1'b0;
    end else begin
      last   <= last_d;
      sel    <= sel_d;
      a_lat  <= a_d;
      b_lat  <= b_d;
      op_lat <= op_d;
      gnt0   <= gnt0_d;
      gnt1   <= gnt1_d;
      done0  <= done0_d;
      done1  <= done1_d;
      result <= result_d;
      c      <= c_d;
      n      <= n_d;
      z      <= z_d;
      v      <= v_d;
    end
  end
endmodule

// File: tb/tb_alu4_arbiter.sv
// Bench for alu4_arbiter: vector table, hand-written multi-cycle sequences,
// and randomized transactions against an arithmetic reference model.
module tb_alu4_arbiter;
  logic       clk;
  logic       reset_n;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic [2:0] op0, op1;
  logic       gnt0, gnt1, done0, done1;
  logic [3:0] result;
  logic       c, n, z, v;

  int checks   = 0;
  int failures = 0;
  logic model_last;

  alu4_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0),
    .a0      (a0),
    .b0      (b0),
    .op0     (op0),
    .req1    (req1),
    .a1      (a1),
    .b1      (b1),
    .op1     (op1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .done0   (done0),
    .done1   (done1),
    .result  (result),
    .c       (c),
    .n       (n),
    .z       (z),
    .v       (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [2:0] op0;
    logic [3:0] a1;
    logic [3:0] b1;
    logic [2:0] op1;
    logic       who;
    logic [7:0] exp;   // {result, c, n, z, v}
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {gnt0, gnt1, done0, done1};
  endfunction

  function automatic logic [7:0] outs();
    return {result, c, n, z, v};
  endfunction

  // Reference ALU from integer arithmetic and signed range checks.
  function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int ai, bi, sa, sb, r, sr;
    logic [3:0] y;
    logic cy, ov;
    ai = int'(a);
    bi = int'(b);
    sa = (ai >= 8) ? ai - 16 : ai;
    sb = (bi >= 8) ? bi - 16 : bi;
    cy = 1'b0;
    ov = 1'b0;
    y  = 4'h0;
    case (op)
      3'd0: y = ~a;
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd6: begin
        r  = ai + bi;
        sr = sa + sb;
        y  = 4'(r);
        cy = (r > 15);
        ov = (sr > 7) || (sr < -8);
      end
      3'd7: begin
        r  = ai - bi;
        sr = sa - sb;
        y  = 4'(r);
        cy = (ai >= bi);
        ov = (sr > 7) || (sr < -8);
      end
      default: y = 4'h0;
    endcase
    return {y, cy, y[3], (y == 4'h0), ov};
  endfunction

  // One full transaction from IDLE: grant, done with result, then back to idle.
  task automatic serve(input string name, input logic r0, input logic r1,
                       input logic who, input logic [7:0] exp);
    req0 = r0;
    req1 = r1;
    tick();
    check({name, " gnt"}, 32'(strobes()), 32'({~who, who, 2'b00}));
    tick();
    check({name, " done"}, 32'(strobes()), 32'({~who, who, ~who, who}));
    check({name, " result"}, 32'(outs()), 32'(exp));
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check({name, " idle"}, 32'(strobes()), 32'h0);
    model_last = who;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_last = 1'b1;
  endtask

  vec_t vecs[12];
  logic [2:0] ops[6];

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1, 1, 4'h0, 4'h0, 3'd0, 4'h9, 4'h9, 3'd6, 1'b0, 8'hF4};
    vecs[1]  = '{1, 0, 4'h0, 4'h0, 3'd0, 4'h0, 4'h0, 3'd0, 1'b0, 8'hF4};
    vecs[2]  = '{0, 1, 4'h0, 4'h0, 3'd0, 4'h5, 4'h3, 3'd6, 1'b1, 8'h85};
    vecs[3]  = '{0, 1, 4'h0, 4'h0, 3'd0, 4'h7, 4'h1, 3'd7, 1'b1, 8'h68};
    vecs[4]  = '{0, 1, 4'h0, 4'h0, 3'd0, 4'hF, 4'h1, 3'd6, 1'b1, 8'h0A};
    vecs[5]  = '{1, 0, 4'h8, 4'h1, 3'd7, 4'h0, 4'h0, 3'd0, 1'b0, 8'h79};
    vecs[6]  = '{1, 0, 4'h0, 4'h1, 3'd7, 4'h0, 4'h0, 3'd0, 1'b0, 8'hF4};
    vecs[7]  = '{1, 0, 4'h7, 4'h1, 3'd6, 4'h0, 4'h0, 3'd0, 1'b0, 8'h85};
    vecs[8]  = '{0, 1, 4'h0, 4'h0, 3'd0, 4'h3, 4'h3, 3'd7, 1'b1, 8'h0A};
    vecs[9]  = '{1, 1, 4'hA, 4'hC, 3'd2, 4'h1, 4'h1, 3'd6, 1'b0, 8'h84};
    vecs[10] = '{1, 1, 4'h1, 4'h1, 3'd6, 4'hA, 4'h5, 3'd3, 1'b1, 8'hF4};
    vecs[11] = '{1, 1, 4'h6, 4'h6, 3'd4, 4'h2, 4'h2, 3'd6, 1'b0, 8'h02};
    ops = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};

    reset_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    a0 = '0; b0 = '0; op0 = '0;
    a1 = '0; b1 = '0; op1 = '0;
    model_last = 1'b1;
    repeat (2) tick();
    check("reset strobes", 32'(strobes()), 32'h0);
    check("reset outs", 32'(outs()), 32'h0);
    reset_n = 1'b1;

    // Vector table; the first row is the post-reset tie.
    for (int i = 0; i < 12; i++) begin
      a0 = vecs[i].a0; b0 = vecs[i].b0; op0 = vecs[i].op0;
      a1 = vecs[i].a1; b1 = vecs[i].b1; op1 = vecs[i].op1;
      serve($sformatf("vec%0d", i), vecs[i].r0, vecs[i].r1, vecs[i].who, vecs[i].exp);
    end

    // Continuous contention: strict alternation starting with requester 0.
    pulse_reset();
    a0 = 4'h5; b0 = 4'h3; op0 = 3'd2;
    a1 = 4'h5; b1 = 4'h3; op1 = 3'd4;
    req0 = 1'b1; req1 = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      int ph;
      logic w;
      logic [3:0] es;
      tick();
      ph = (t - 1) % 3;
      w  = 1'(((t - 1) / 3) % 2);
      es = {(ph < 2) & ~w, (ph < 2) & w, (ph == 1) & ~w, (ph == 1) & w};
      check($sformatf("contend t%0d strobes", t), 32'(strobes()), 32'(es));
      check($sformatf("contend t%0d gnt overlap", t), 32'(gnt0 & gnt1), 32'h0);
      if (ph == 1)
        check($sformatf("contend t%0d result", t), 32'(outs()), w ? 32'h60 : 32'h10);
    end
    req0 = 1'b0; req1 = 1'b0;
    model_last = 1'b1;

    // Operand change during EXEC is ignored; result holds afterwards.
    a0 = 4'h5; b0 = 4'h3; op0 = 3'd3;
    req0 = 1'b1;
    tick();
    check("stable gnt", 32'(strobes()), 32'h8);
    a0 = 4'hF;
    tick();
    check("stable done", 32'(strobes()), 32'hA);
    check("stable result", 32'(outs()), 32'h70);
    req0 = 1'b0;
    model_last = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      check($sformatf("hold%0d result", t), 32'(outs()), 32'h70);
      check($sformatf("hold%0d strobes", t), 32'(strobes()), 32'h0);
    end

    // Reset during EXEC with pointer at 0: no done, pointer back to 1.
    a0 = 4'h1; b0 = 4'h1; op0 = 3'd6;
    req0 = 1'b1;
    tick();
    check("abort gnt", 32'(strobes()), 32'h8);
    #2 reset_n = 1'b0;
    #1;
    check("abort immediate strobes", 32'(strobes()), 32'h0);
    check("abort immediate outs", 32'(outs()), 32'h0);
    tick();
    check("abort no done", 32'(strobes()), 32'h0);
    reset_n = 1'b1;
    model_last = 1'b1;
    a1 = 4'h2; b1 = 4'h3; op1 = 3'd6;
    serve("after abort tie", 1'b1, 1'b1, 1'b0, 8'h20);
    serve("after abort req1", 1'b0, 1'b1, 1'b1, 8'h50);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      int p;
      logic r0, r1, who;
      logic [7:0] exp;
      p  = int'($urandom_range(0, 2));
      r0 = (p != 1);
      r1 = (p != 0);
      a0 = 4'($urandom); b0 = 4'($urandom); op0 = ops[$urandom_range(0, 5)];
      a1 = 4'($urandom); b1 = 4'($urandom); op1 = ops[$urandom_range(0, 5)];
      who = (r0 & r1) ? ~model_last : r1;
      exp = who ? ref_alu(a1, b1, op1) : ref_alu(a0, b0, op0);
      serve($sformatf("rand%0d", i), r0, r1, who, exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
